// File: rtl/mem_arb_pkg.sv
// Shared types and width helper for the unified memory-port arbiter.
package mem_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_WAIT} arb_state_t;
  typedef enum logic {OWN_IF, OWN_D} arb_owner_t;

  // Bits needed to count 0..v-1, never less than 1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester (IF, D) and memory-side signals of the shared memory port.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_addr, mem_we, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/mem_arb_pick.sv
// Winner select: D has priority unless IF has been passed over MAX_STREAK times.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic       if_req,
  input  logic       d_req,
  input  logic       streak_max,
  output arb_owner_t winner,
  output logic       any_req
);

  always_comb begin
    any_req = if_req | d_req;
    winner  = (d_req && !(if_req && streak_max)) ? OWN_D : OWN_IF;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one access in flight.
//   state    | meaning
//   ARB_IDLE | no access in flight; grant the winner combinationally
//   ARB_WAIT | access issued; count down memory latency, then return data to owner
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int MAX_STREAK = 4
) (
  input logic               clk,
  input logic               rst_n,
  mem_port_arbiter_if.slave bus
);

  localparam int LAT_W    = clog2(MEM_LAT);
  localparam int STREAK_W = clog2(MAX_STREAK + 1);

  arb_state_t          state_q, state_d;
  arb_owner_t          owner_q, owner_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic [STREAK_W-1:0] streak_q, streak_d;

  arb_owner_t          winner;
  logic                any_req;
  logic                streak_max;

  logic                if_gnt, if_rvalid, d_gnt, d_rvalid, mem_we;
  logic [DATA_W-1:0]   if_rdata, d_rdata, mem_wdata;
  logic [ADDR_W-1:0]   mem_addr;

  assign streak_max = (streak_q == STREAK_W'(MAX_STREAK));

  mem_arb_pick u_pick (
    .if_req     (bus.if_req),
    .d_req      (bus.d_req),
    .streak_max (streak_max),
    .winner     (winner),
    .any_req    (any_req)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ARB_IDLE;
      owner_q  <= OWN_IF;
      we_q     <= 1'b0;
      addr_q   <= '0;
      lat_q    <= '0;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      lat_q    <= lat_d;
      streak_q <= streak_d;
    end
  end

  // Everything is gated by rst_n so a held request cannot leak a grant during reset.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    we_d      = we_q;
    addr_d    = addr_q;
    lat_d     = lat_q;
    streak_d  = streak_q;
    if_gnt    = 1'b0;
    if_rvalid = 1'b0;
    if_rdata  = '0;
    d_gnt     = 1'b0;
    d_rvalid  = 1'b0;
    d_rdata   = '0;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (rst_n) begin
      case (state_q)
        ARB_IDLE: begin
          if (any_req) begin
            state_d = ARB_WAIT;
            owner_d = winner;
            lat_d   = LAT_W'(MEM_LAT - 1);
            if (winner == OWN_D) begin
              d_gnt     = 1'b1;
              mem_addr  = bus.d_addr;
              mem_we    = bus.d_we;
              mem_wdata = bus.d_wdata;
              addr_d    = bus.d_addr;
              we_d      = bus.d_we;
              if (!bus.if_req) streak_d = '0;
              else if (!streak_max) streak_d = STREAK_W'(streak_q + 1'b1);
            end else begin
              if_gnt   = 1'b1;
              mem_addr = bus.if_addr;
              addr_d   = bus.if_addr;
              we_d     = 1'b0;
              streak_d = '0;
            end
          end
        end
        ARB_WAIT: begin
          mem_addr = addr_q;
          if (lat_q == '0) begin
            state_d = ARB_IDLE;
            if (owner_q == OWN_D) begin
              d_rvalid = 1'b1;
              d_rdata  = we_q ? '0 : bus.mem_rdata;
            end else begin
              if_rvalid = 1'b1;
              if_rdata  = bus.mem_rdata;
            end
          end else begin
            lat_d = LAT_W'(lat_q - 1'b1);
          end
        end
        default: state_d = ARB_IDLE;
      endcase
    end
  end

  assign bus.if_gnt    = if_gnt;
  assign bus.if_rvalid = if_rvalid;
  assign bus.if_rdata  = if_rdata;
  assign bus.d_gnt     = d_gnt;
  assign bus.d_rvalid  = d_rvalid;
  assign bus.d_rdata   = d_rdata;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_we    = mem_we;
  assign bus.mem_wdata = mem_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: two arbiters (MEM_LAT=1 and MEM_LAT=3), each with a small behavioural memory.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst1_n, rst3_n;
  logic       pl_en;
  logic [5:0] pl_a;
  logic [31:0] pl_d;

  int n_chk = 0;
  int n_err = 0;
  logic seen;
  int exp_d [6] = '{1, 1, 1, 1, 0, 1};

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1 ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b3 ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .MAX_STREAK(4)) dut1 (
    .clk(clk), .rst_n(rst1_n), .bus(b1)
  );
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .MAX_STREAK(4)) dut3 (
    .clk(clk), .rst_n(rst3_n), .bus(b3)
  );

  // Memories sample the address at posedge and present data MEM_LAT cycles later.
  logic [31:0] mem1 [0:63];
  logic [31:0] mem3 [0:63];
  logic [5:0]  p1, q0, q1, q2;

  always @(posedge clk) begin
    if (pl_en) begin
      mem1[pl_a] <= pl_d;
      mem3[pl_a] <= pl_d;
    end else begin
      if (b1.mem_we) mem1[b1.mem_addr[5:0]] <= b1.mem_wdata;
      if (b3.mem_we) mem3[b3.mem_addr[5:0]] <= b3.mem_wdata;
    end
    p1 <= b1.mem_addr[5:0];
    q0 <= b3.mem_addr[5:0];
    q1 <= q0;
    q2 <= q1;
  end

  assign b1.mem_rdata = mem1[p1];
  assign b3.mem_rdata = mem3[q2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic preload(input logic [5:0] a, input logic [31:0] d);
    pl_en = 1'b1; pl_a = a; pl_d = d;
    @(posedge clk);
    #1;
    pl_en = 1'b0;
  endtask

  initial begin
    rst1_n = 1'b0; rst3_n = 1'b0;
    pl_en = 1'b0; pl_a = '0; pl_d = '0;
    b1.if_req = 0; b1.if_addr = '0; b1.d_req = 0; b1.d_we = 0; b1.d_addr = '0; b1.d_wdata = '0;
    b3.if_req = 0; b3.if_addr = '0; b3.d_req = 0; b3.d_we = 0; b3.d_addr = '0; b3.d_wdata = '0;

    preload(6'd5, 32'h0050_0093);
    preload(6'd7, 32'h1111_1111);
    preload(6'd8, 32'h2222_2222);
    preload(6'd3, 32'h1234_5678);

    // Reset with requests held: everything must stay 0.
    b1.if_req = 1; b1.if_addr = 32'h9; b1.d_req = 1; b1.d_we = 1;
    b1.d_addr = 32'hA; b1.d_wdata = 32'hFF;
    #1;
    check("rst_gnt", {b1.if_gnt, b1.d_gnt, b1.if_rvalid, b1.d_rvalid, b1.mem_we}, 0);
    check("rst_mem_addr", b1.mem_addr, 0);
    check("rst_mem_wdata", b1.mem_wdata, 0);
    check("rst_rdata", b1.if_rdata | b1.d_rdata, 0);
    b1.if_req = 0; b1.d_req = 0; b1.d_we = 0;
    step();
    rst1_n = 1; rst3_n = 1;
    step();
    #1;
    check("idle_mem_addr", b1.mem_addr, 0);

    // IF-only fetch, MEM_LAT=1
    b1.if_req = 1; b1.if_addr = 32'd5;
    #1;
    check("if_gnt", b1.if_gnt, 1);
    check("if_mem_addr", b1.mem_addr, 5);
    check("if_mem_we", b1.mem_we, 0);
    step();
    b1.if_req = 0;
    #1;
    check("if_rvalid", b1.if_rvalid, 1);
    check("if_rdata", b1.if_rdata, 32'h0050_0093);
    check("if_wait_gnt", b1.if_gnt, 0);
    check("if_d_rvalid", b1.d_rvalid, 0);
    step();
    check("if_rvalid_off", b1.if_rvalid, 0);

    // Store then load of the same address
    b1.d_req = 1; b1.d_we = 1; b1.d_addr = 32'h20; b1.d_wdata = 32'hDEAD_BEEF;
    #1;
    check("st_gnt", b1.d_gnt, 1);
    check("st_mem_we", b1.mem_we, 1);
    check("st_mem_wdata", b1.mem_wdata, 32'hDEAD_BEEF);
    step();
    b1.d_req = 0; b1.d_we = 0;
    #1;
    check("st_wait_we", b1.mem_we, 0);
    check("st_ack", b1.d_rvalid, 1);
    check("st_ack_rdata", b1.d_rdata, 0);
    check("st_if_rvalid", b1.if_rvalid, 0);
    step();
    b1.d_req = 1; b1.d_we = 0; b1.d_addr = 32'h20;
    #1;
    check("ld_gnt", b1.d_gnt, 1);
    check("ld_mem_we", b1.mem_we, 0);
    step();
    b1.d_req = 0;
    #1;
    check("ld_rvalid", b1.d_rvalid, 1);
    check("ld_rdata", b1.d_rdata, 32'hDEAD_BEEF);
    step();

    // Both requesting: four D grants, then IF forced, then D resumes
    b1.if_req = 1; b1.if_addr = 32'd7; b1.d_req = 1; b1.d_we = 0; b1.d_addr = 32'd8;
    for (int g = 0; g < 6; g++) begin
      #1;
      check($sformatf("arb_d_gnt%0d", g), b1.d_gnt, exp_d[g]);
      check($sformatf("arb_if_gnt%0d", g), b1.if_gnt, exp_d[g] == 0);
      step();
      if (exp_d[g] == 0) b1.if_req = 0;
      #1;
      check($sformatf("arb_wait_gnt%0d", g), b1.d_gnt | b1.if_gnt, 0);
      check($sformatf("arb_d_rv%0d", g), b1.d_rvalid, exp_d[g]);
      check($sformatf("arb_if_rv%0d", g), b1.if_rvalid, exp_d[g] == 0);
      check($sformatf("arb_rdata%0d", g), exp_d[g] != 0 ? b1.d_rdata : b1.if_rdata,
            exp_d[g] != 0 ? 32'h2222_2222 : 32'h1111_1111);
      step();
    end
    b1.d_req = 0;
    step();

    // IF request raised and dropped while D is in flight
    b1.d_req = 1; b1.d_addr = 32'd8;
    #1;
    check("wd_d_gnt", b1.d_gnt, 1);
    step();
    b1.d_req = 0; b1.if_req = 1; b1.if_addr = 32'd7;
    #1;
    check("wd_if_gnt_wait", b1.if_gnt, 0);
    check("wd_d_rvalid", b1.d_rvalid, 1);
    step();
    b1.if_req = 0;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      seen = seen | b1.if_gnt | b1.if_rvalid;
      step();
    end
    check("wd_no_if", seen, 0);

    // MEM_LAT=3 timing
    b3.d_req = 1; b3.d_we = 0; b3.d_addr = 32'd3; b3.if_req = 1; b3.if_addr = 32'd5;
    #1;
    check("l3_d_gnt", b3.d_gnt, 1);
    check("l3_if_gnt0", b3.if_gnt, 0);
    step();
    b3.d_req = 0;
    for (int k = 1; k <= 3; k++) begin
      #1;
      check($sformatf("l3_we%0d", k), b3.mem_we, 0);
      check($sformatf("l3_addr%0d", k), b3.mem_addr, 3);
      check($sformatf("l3_if_gnt%0d", k), b3.if_gnt, 0);
      check($sformatf("l3_rvalid%0d", k), b3.d_rvalid, k == 3);
      check($sformatf("l3_rdata%0d", k), b3.d_rdata, k == 3 ? 32'h1234_5678 : 32'h0);
      step();
    end
    #1;
    check("l3_next_gnt", b3.if_gnt, 1);
    check("l3_next_addr", b3.mem_addr, 5);
    step();
    b3.if_req = 0;
    step();
    step();
    #1;
    check("l3_if_rvalid", b3.if_rvalid, 1);
    check("l3_if_rdata", b3.if_rdata, 32'h0050_0093);
    step();

    // Reset during WAIT after a store was issued
    b3.d_req = 1; b3.d_we = 1; b3.d_addr = 32'd10; b3.d_wdata = 32'hCAFE_F00D;
    #1;
    check("rw_st_gnt", b3.d_gnt, 1);
    step();
    b3.d_we = 0; b3.if_req = 1;
    rst3_n = 0;
    #1;
    check("rw_gnt", {b3.if_gnt, b3.d_gnt, b3.if_rvalid, b3.d_rvalid, b3.mem_we}, 0);
    check("rw_mem_addr", b3.mem_addr, 0);
    check("rw_mem_wdata", b3.mem_wdata, 0);
    check("rw_rdata", b3.if_rdata | b3.d_rdata, 0);
    step();
    check("rw_gnt_hold", b3.if_gnt | b3.d_gnt, 0);
    b3.if_req = 0; b3.d_req = 0;
    rst3_n = 1;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      seen = seen | b3.if_rvalid | b3.d_rvalid | b3.if_gnt | b3.d_gnt;
      step();
    end
    check("rw_no_rvalid", seen, 0);
    b3.if_req = 1; b3.if_addr = 32'd5; b3.d_req = 1; b3.d_we = 0; b3.d_addr = 32'd10;
    #1;
    check("rw_first_d", b3.d_gnt, 1);
    check("rw_first_if", b3.if_gnt, 0);
    step();
    b3.d_req = 0;
    step();
    step();
    #1;
    check("rw_ld_rvalid", b3.d_rvalid, 1);
    check("rw_ld_rdata", b3.d_rdata, 32'hCAFE_F00D);
    step();
    b3.if_req = 0;
    step();
    step();
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
